// File: rtl/fetch_unit_pkg.sv
// Shared fetch definitions: FSM states, instruction field positions and the abort instruction.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_DONE = 2'd2
  } fetch_state_e;

  localparam int OPC_MSB = 7;
  localparam int OPC_LSB = 4;
  localparam int RD_MSB  = 3;
  localparam int RD_LSB  = 2;
  localparam int RS_MSB  = 1;
  localparam int RS_LSB  = 0;

  // opcode[3]=1 makes the controller halt in ID
  localparam logic [7:0] FETCH_ERR_INSTR = 8'hF0;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read channel between the fetch unit (master) and memory (slave).
interface fetch_unit_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 8
);
  logic               mem_req;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_ack;
  logic [INSTR_W-1:0] mem_rdata;

  modport master (output mem_req, mem_addr, input mem_ack, mem_rdata);
  modport slave  (input mem_req, mem_addr, output mem_ack, mem_rdata);
endinterface

// File: rtl/fetch_unit_watchdog.sv
// Request timeout counter; expired fires in the REQ cycle whose miss brings the count to TIMEOUT.
module fetch_watchdog #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);

  logic [7:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (run) begin
      count <= count + 8'd1;
    end
  end

  assign expired = run && (count == 8'(TIMEOUT - 1));

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch responder: latches pc, handshakes with memory, pulses en1 and holds ir fields.
// Optional request timeout/abort enabled by defining FETCH_TIMEOUT_EN.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 8,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en_fetch_pulse,
  input  logic [ADDR_W-1:0]  pc,
  fetch_unit_if.master       mem,
  output logic               en1,
  output logic [INSTR_W-1:0] ir,
  output logic [3:0]         opcode,
  output logic [1:0]         rd,
  output logic [1:0]         rs,
  output logic               busy,
  output logic               fetch_err
);

  fetch_state_e state;

`ifdef FETCH_TIMEOUT_EN
  logic expired;

  fetch_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (state == FETCH_IDLE && en_fetch_pulse),
    .run     (state == FETCH_REQ && !mem.mem_ack),
    .expired (expired)
  );
`else
  assign fetch_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= FETCH_IDLE;
      mem.mem_req  <= 1'b0;
      mem.mem_addr <= '0;
      en1          <= 1'b0;
      ir           <= '0;
      busy         <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      fetch_err    <= 1'b0;
`endif
    end else begin
      en1 <= 1'b0;
      case (state)
        FETCH_IDLE: begin
          if (en_fetch_pulse) begin
            mem.mem_addr <= pc;
            mem.mem_req  <= 1'b1;
            busy         <= 1'b1;
            state        <= FETCH_REQ;
          end
        end
        FETCH_REQ: begin
          // ack has priority over a coincident timeout
          if (mem.mem_ack) begin
            ir          <= mem.mem_rdata;
            mem.mem_req <= 1'b0;
            en1         <= 1'b1;
            state       <= FETCH_DONE;
          end
`ifdef FETCH_TIMEOUT_EN
          else if (expired) begin
            ir          <= INSTR_W'(FETCH_ERR_INSTR);
            fetch_err   <= 1'b1;
            mem.mem_req <= 1'b0;
            en1         <= 1'b1;
            state       <= FETCH_DONE;
          end
`endif
        end
        FETCH_DONE: begin
          busy  <= 1'b0;
          state <= FETCH_IDLE;
        end
        default: begin
          mem.mem_req <= 1'b0;
          busy        <= 1'b0;
          state       <= FETCH_IDLE;
        end
      endcase
    end
  end

  assign opcode = ir[OPC_MSB:OPC_LSB];
  assign rd     = ir[RD_MSB:RD_LSB];
  assign rs     = ir[RS_MSB:RS_LSB];

endmodule
